pwm_audio_out: RTL and testbench

Parametrised audio output stage that replaces the fixed 8-bit volume shift and free-running PWM pair.
- Takes signed samples from the FIR/ANC path on a valid pulse.
- Applies gain and volume:
  - gain is a left shift with saturation, not wrap;
  - volume is an attenuation shift.
- Converts to offset-binary and drives a glitch-free PWM. The duty cycle updates only on period boundaries.
- Adds a pop-free mute/fade state machine and an amplifier shutdown output.
- Sits between the anti-noise filter output and the speaker pin driver.

---
 rtl/pwm_audio_out_if.sv | 25 ++
 rtl/pwm_audio_out.sv | 134 +++++++++++++
 tb/tb_pwm_audio_out.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pwm_audio_out_if.sv
// Sample/control and PWM output bundle for pwm_audio_out.
interface pwm_audio_out_if #(
    parameter int DATA_W  = 16,
    parameter int SHIFT_W = 4
);
    logic [DATA_W-1:0]  sample_in;
    logic               sample_valid_in;
    logic [SHIFT_W-1:0] shift_in;
    logic [2:0]         vol_in;
    logic               mute_in;
    logic               pwm_out;
    logic               sd_out;
    logic               clip_out;
    logic               period_start_out;

    modport master (
        output sample_in, sample_valid_in, shift_in, vol_in, mute_in,
        input  pwm_out, sd_out, clip_out, period_start_out
    );

    modport slave (
        input  sample_in, sample_valid_in, shift_in, vol_in, mute_in,
        output pwm_out, sd_out, clip_out, period_start_out
    );
endinterface

// File: rtl/pwm_audio_out.sv
// Audio output stage: saturating gain, volume attenuation, offset-binary PWM, mute fade FSM.
// Optional macro FADE_DITHER_EN adds first-order error-feedback on the truncated sample bits.
module pwm_audio_out #(
    parameter int DATA_W  = 16,
    parameter int PWM_W   = 8,
    parameter int SHIFT_W = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    pwm_audio_out_if.slave bus
);
    localparam int G_W    = DATA_W + 2**SHIFT_W;
    localparam int FRAC_W = DATA_W - PWM_W;
    localparam int TOP_W  = G_W - FRAC_W;
    localparam int R_W    = $clog2(PWM_W + 1);
    localparam logic [R_W-1:0]          R_FULL   = R_W'(PWM_W);
    localparam logic [PWM_W-1:0]        MIDSCALE = {1'b1, {(PWM_W-1){1'b0}}};
    localparam logic signed [PWM_W-1:0] S_MAX    = {1'b0, {(PWM_W-1){1'b1}}};
    localparam logic signed [PWM_W-1:0] S_MIN    = {1'b1, {(PWM_W-1){1'b0}}};

    typedef enum logic [1:0] {PLAY, FADE_OUT, MUTE, FADE_IN} state_t;

    state_t                   state, state_next;
    logic [R_W-1:0]           r, r_next;
    logic [PWM_W-1:0]         count, active, load_level;
    logic signed [PWM_W-1:0]  pending, s_val, a_val, faded;
    logic signed [G_W-1:0]    sample_ext;
    logic signed [TOP_W-1:0]  g_top;
    logic [TOP_W-PWM_W:0]     g_hi;
    logic [2:0]               atten;
    logic                     ovf, load;
    logic                     pwm_q, clip_q, period_start_q;
`ifdef FADE_DITHER_EN
    logic [FRAC_W-1:0]        acc, acc_sum, frac;
    logic                     carry;
`endif

    assign load = (count == '1);

    // Only the bits that survive into the PWM level are kept; the saturation
    // test looks at everything above the level's sign bit.
    always_comb begin
        sample_ext = {{(G_W-DATA_W){bus.sample_in[DATA_W-1]}}, bus.sample_in};
        g_top      = TOP_W'((sample_ext <<< bus.shift_in) >>> FRAC_W);
        g_hi       = g_top[TOP_W-1:PWM_W-1];
        ovf        = !((&g_hi) || !(|g_hi));
        s_val      = ovf ? (g_top[TOP_W-1] ? S_MIN : S_MAX) : g_top[PWM_W-1:0];
`ifdef FADE_DITHER_EN
        frac             = ovf ? {FRAC_W{!g_top[TOP_W-1]}} : FRAC_W'(sample_ext <<< bus.shift_in);
        {carry, acc_sum} = {1'b0, acc} + {1'b0, frac};
        if (carry && (s_val != S_MAX)) begin
            s_val = s_val + 1'b1;
        end
`endif
        atten = 3'd7 - bus.vol_in;
        a_val = s_val >>> atten;
    end

    always_comb begin
        state_next = state;
        r_next     = r;
        unique case (state)
            PLAY: if (load && bus.mute_in) begin
                r_next     = r + 1'b1;
                state_next = (r_next == R_FULL) ? MUTE : FADE_OUT;
            end
            FADE_OUT: if (load) begin
                if (!bus.mute_in) begin
                    state_next = FADE_IN;
                end else begin
                    r_next = r + 1'b1;
                    if (r_next == R_FULL) state_next = MUTE;
                end
            end
            MUTE: if (!bus.mute_in) state_next = FADE_IN;
            FADE_IN: if (load) begin
                if (bus.mute_in) begin
                    state_next = FADE_OUT;
                end else begin
                    r_next = r - 1'b1;
                    if (r_next == '0) state_next = PLAY;
                end
            end
        endcase
    end

    // The level loaded at a boundary already reflects that boundary's fade step.
    always_comb begin
        faded      = pending >>> r_next;
        load_level = (r_next == R_FULL) ? MIDSCALE : (faded ^ MIDSCALE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= MUTE;
            r     <= R_FULL;
        end else begin
            state <= state_next;
            r     <= r_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count          <= '0;
            active         <= MIDSCALE;
            pending        <= '0;
            pwm_q          <= 1'b0;
            clip_q         <= 1'b0;
            period_start_q <= 1'b0;
`ifdef FADE_DITHER_EN
            acc            <= '0;
`endif
        end else begin
            count          <= count + 1'b1;
            period_start_q <= load;
            pwm_q          <= (count < active);
            clip_q         <= 1'b0;
            if (load) active <= load_level;
            if (bus.sample_valid_in) begin
                pending <= a_val;
                clip_q  <= ovf;
`ifdef FADE_DITHER_EN
                acc     <= acc_sum;
`endif
            end
        end
    end

    assign bus.pwm_out          = pwm_q;
    assign bus.sd_out           = (state != MUTE);
    assign bus.clip_out         = clip_q;
    assign bus.period_start_out = period_start_q;
endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: per-period PWM high counts against hand-computed levels.
module tb_pwm_audio_out;
    localparam int DATA_W  = 16;
    localparam int PWM_W   = 8;
    localparam int SHIFT_W = 4;
    localparam int PERIOD  = 2**PWM_W;

    typedef struct {
        logic [DATA_W-1:0]  sample;
        logic [SHIFT_W-1:0] shift;
        logic [2:0]         vol;
        int                 level;
        int                 clips;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    pwm_audio_out_if #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W)) bus();

    pwm_audio_out #(.DATA_W(DATA_W), .PWM_W(PWM_W), .SHIFT_W(SHIFT_W)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int clip_cnt = 0;

    always @(negedge clk_in) if (bus.clip_out) clip_cnt++;

    vec_t vecs[12];
    int fade_in_lv[8]  = '{128, 129, 130, 132, 136, 144, 160, 192};
    int fade_out_lv[8] = '{160, 144, 136, 132, 130, 129, 128, 128};
    int reverse_lv[6]  = '{136, 136, 144, 160, 192, 192};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic measure(output int h);
        h = 0;
        repeat (PERIOD) begin
            @(negedge clk_in);
            h += int'(bus.pwm_out);
        end
    endtask

    task automatic expect_level(input string name, input int exp);
        int h;
        measure(h);
        check(name, h, exp);
    endtask

    task automatic sync_period(input string name);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!bus.period_start_out && n < 2*PERIOD);
        check(name, int'(bus.period_start_out), 1);
    endtask

    task automatic pulse_valid(input logic [DATA_W-1:0] smp, input logic [SHIFT_W-1:0] sh, input logic [2:0] vol);
        bus.sample_in       = smp;
        bus.shift_in        = sh;
        bus.vol_in          = vol;
        bus.sample_valid_in = 1'b1;
        @(negedge clk_in);
        bus.sample_valid_in = 1'b0;
    endtask

    initial begin
        int c0, n;
        vecs[0]  = '{16'h4000, 4'd0,  3'd7, 192, 0};
        vecs[1]  = '{16'h4000, 4'd2,  3'd7, 255, 1};
        vecs[2]  = '{16'hC000, 4'd2,  3'd7, 0,   1};
        vecs[3]  = '{16'h8000, 4'd0,  3'd5, 96,  0};
        vecs[4]  = '{16'h7FFF, 4'd0,  3'd7, 255, 0};
        vecs[5]  = '{16'h0100, 4'd3,  3'd7, 136, 0};
        vecs[6]  = '{16'hFFFF, 4'd15, 3'd7, 0,   0};
        vecs[7]  = '{16'h0001, 4'd15, 3'd7, 255, 1};
        vecs[8]  = '{16'h4000, 4'd0,  3'd0, 128, 0};
        vecs[9]  = '{16'h8000, 4'd0,  3'd0, 127, 0};
        vecs[10] = '{16'h7FFF, 4'd0,  3'd3, 135, 0};
        vecs[11] = '{16'h4000, 4'd0,  3'd7, 192, 0};

        bus.sample_in       = '0;
        bus.sample_valid_in = 1'b0;
        bus.shift_in        = '0;
        bus.vol_in          = 3'd7;
        bus.mute_in         = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_pwm", int'(bus.pwm_out), 0);
        check("rst_sd", int'(bus.sd_out), 0);
        check("rst_clip", int'(bus.clip_out), 0);
        check("rst_period_start", int'(bus.period_start_out), 0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("sd_after_release", int'(bus.sd_out), 1);

        // Sample loaded during fade-in makes each fade step visible.
        pulse_valid(16'h4000, 4'd0, 3'd7);
        sync_period("sync_fade_in");
        for (int i = 0; i < 8; i++) expect_level($sformatf("fade_in%0d", i), fade_in_lv[i]);
        expect_level("play_steady", 192);

        for (int i = 0; i < 12; i++) begin
            c0 = clip_cnt;
            pulse_valid(vecs[i].sample, vecs[i].shift, vecs[i].vol);
            repeat (PERIOD-1) @(negedge clk_in);
            expect_level($sformatf("vec%0d_level", i), vecs[i].level);
            check($sformatf("vec%0d_clips", i), clip_cnt - c0, vecs[i].clips);
        end

        bus.mute_in = 1'b1;
        repeat (PERIOD) @(negedge clk_in);
        check("sd_fading_out", int'(bus.sd_out), 1);
        for (int i = 0; i < 8; i++) expect_level($sformatf("fade_out%0d", i), fade_out_lv[i]);
        check("sd_muted", int'(bus.sd_out), 0);
        expect_level("mute_midscale", 128);
        bus.mute_in = 1'b0;
        @(negedge clk_in);
        check("sd_unmute", int'(bus.sd_out), 1);
        repeat (PERIOD-1) @(negedge clk_in);
        for (int i = 0; i < 8; i++) expect_level($sformatf("refade_in%0d", i), fade_in_lv[i]);

        bus.mute_in = 1'b1;
        repeat (PERIOD) @(negedge clk_in);
        expect_level("rev_out0", 160);
        expect_level("rev_out1", 144);
        bus.mute_in = 1'b0;
        for (int i = 0; i < 6; i++) expect_level($sformatf("rev_in%0d", i), reverse_lv[i]);

        // Valid on the load cycle: the boundary still uses the old level.
        repeat (PERIOD-1) @(negedge clk_in);
        pulse_valid(16'h2000, 4'd0, 3'd7);
        check("boundary_align", int'(bus.period_start_out), 1);
        expect_level("boundary_old", 192);
        expect_level("boundary_new", 160);

        pulse_valid(16'h8000, 4'd0, 3'd7);
        repeat (8) @(negedge clk_in);
        pulse_valid(16'h6000, 4'd0, 3'd7);
        repeat (PERIOD-10) @(negedge clk_in);
        expect_level("latest_wins", 224);

        repeat (100) @(negedge clk_in);
        bus.mute_in = 1'b1;
        rst_in = 1'b1;
        @(negedge clk_in);
        check("midrst_pwm", int'(bus.pwm_out), 0);
        check("midrst_sd", int'(bus.sd_out), 0);
        check("midrst_clip", int'(bus.clip_out), 0);
        check("midrst_period_start", int'(bus.period_start_out), 0);
        rst_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!bus.period_start_out && n < 2*PERIOD);
        check("midrst_first_period", n, PERIOD);
        check("midrst_sd_held", int'(bus.sd_out), 0);
        expect_level("midrst_mute_level", 128);
        bus.mute_in = 1'b0;
        for (int i = 0; i < 9; i++) expect_level($sformatf("midrst_fade%0d", i), 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
